// File: rtl/axi_shell_decouple_ctrl_if.sv
// -----------------------------------------------------------------------------
// axi_shell_decouple_ctrl_if
// Handshake-only view of one side of an AXI4 link: valid/ready for the five
// channels plus the W and R last flags. Data and address payload travel
// beside this controller and are not carried here.
//
// Modports:
//   master - drives AW/AR/W valids, wlast, B/R readies
//   slave  - drives AW/AR/W readies, B/R valids, rlast
// -----------------------------------------------------------------------------
interface axi_shell_decouple_ctrl_if;
    logic awvalid;
    logic awready;
    logic arvalid;
    logic arready;
    logic wvalid;
    logic wready;
    logic wlast;
    logic bvalid;
    logic bready;
    logic rvalid;
    logic rready;
    logic rlast;

    modport master (
        output awvalid, arvalid, wvalid, wlast, bready, rready,
        input  awready, arready, wready, bvalid, rvalid, rlast
    );

    modport slave (
        input  awvalid, arvalid, wvalid, wlast, bready, rready,
        output awready, arready, wready, bvalid, rvalid, rlast
    );
endinterface

// File: rtl/axi_shell_decouple_ctrl.sv
// -----------------------------------------------------------------------------
// axi_shell_decouple_ctrl
// Handshake gate beside the shell-to-user AXI4 register slice. Tracks
// outstanding reads and writes, caps them at MAX_OUTSTANDING, and on request
// stops new address acceptance, drains in-flight bursts and then isolates the
// user region for partial reconfiguration.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   decouple_req    level request to decouple
//   decoupled       user side isolated (registered)
//   drain_timeout   sticky: last drain ended by timeout
//   wr_outstanding  AW accepted minus B accepted
//   rd_outstanding  AR accepted minus R-last accepted
//   s_axi           shell-facing side (this block acts as slave)
//   m_axi           user-facing side (this block acts as master)
//
// States:
//   ACTIVE    | normal pass-through, credit cap enforced on AW/AR
//   DRAIN     | AW/AR blocked, W/B/R flow until idle or timeout
//   DECOUPLED | every channel gated, user region isolated
// -----------------------------------------------------------------------------
module axi_shell_decouple_ctrl #(
    parameter int MAX_OUTSTANDING = 32,
    parameter int CNT_BITS        = 6,
    parameter int DRAIN_TIMEOUT   = 4096,
    parameter int TMR_BITS        = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 decouple_req,
    output logic                 decoupled,
    output logic                 drain_timeout,
    output logic [CNT_BITS-1:0]  wr_outstanding,
    output logic [CNT_BITS-1:0]  rd_outstanding,
    axi_shell_decouple_ctrl_if.slave  s_axi,
    axi_shell_decouple_ctrl_if.master m_axi
);

    localparam logic [CNT_BITS-1:0]        CAP       = CNT_BITS'(MAX_OUTSTANDING);
    localparam logic [TMR_BITS-1:0]        TMO_LAST  = TMR_BITS'(DRAIN_TIMEOUT - 1);
    localparam logic signed [CNT_BITS:0]   PEND_ONE  = (CNT_BITS+1)'(1);

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        DRAIN     = 2'd1,
        DECOUPLED = 2'd2
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic [TMR_BITS-1:0]        timer;
    logic [TMR_BITS-1:0]        timer_next;
    logic signed [CNT_BITS:0]   w_pend;
    logic signed [CNT_BITS:0]   w_pend_next;
    logic [CNT_BITS-1:0]        wr_next;
    logic [CNT_BITS-1:0]        rd_next;
    logic                       clean_enter;
    logic                       force_enter;

    logic aw_en, ar_en, data_en;
    logic aw_hs, ar_hs, wlast_hs, b_hs, rlast_hs;
    logic idle;

    // Enables come only from registers so the gating stays a pure AND path.
    assign aw_en   = (state == ACTIVE) && (wr_outstanding < CAP);
    assign ar_en   = (state == ACTIVE) && (rd_outstanding < CAP);
    assign data_en = (state != DECOUPLED);

    assign m_axi.awvalid = s_axi.awvalid & aw_en;
    assign s_axi.awready = m_axi.awready & aw_en;
    assign m_axi.arvalid = s_axi.arvalid & ar_en;
    assign s_axi.arready = m_axi.arready & ar_en;
    assign m_axi.wvalid  = s_axi.wvalid  & data_en;
    assign s_axi.wready  = m_axi.wready  & data_en;
    assign s_axi.bvalid  = m_axi.bvalid  & data_en;
    assign m_axi.bready  = s_axi.bready  & data_en;
    assign s_axi.rvalid  = m_axi.rvalid  & data_en;
    assign m_axi.rready  = s_axi.rready  & data_en;

    // Last flags are payload; mirrored so each side of the link is fully driven.
    assign m_axi.wlast   = s_axi.wlast;
    assign s_axi.rlast   = m_axi.rlast;

    assign aw_hs    = s_axi.awvalid & m_axi.awready & aw_en;
    assign ar_hs    = s_axi.arvalid & m_axi.arready & ar_en;
    assign wlast_hs = s_axi.wvalid  & m_axi.wready  & data_en & s_axi.wlast;
    assign b_hs     = m_axi.bvalid  & s_axi.bready  & data_en;
    assign rlast_hs = m_axi.rvalid  & s_axi.rready  & data_en & m_axi.rlast;

    assign idle = (wr_outstanding == '0) && (rd_outstanding == '0) && (w_pend == '0);

    // Counter next values; a decrement at zero is a protocol error and holds.
    always_comb begin
        wr_next = wr_outstanding;
        if (aw_hs && !b_hs) begin
            wr_next = wr_outstanding + 1'b1;
        end else if (!aw_hs && b_hs && (wr_outstanding != '0)) begin
            wr_next = wr_outstanding - 1'b1;
        end
    end

    always_comb begin
        rd_next = rd_outstanding;
        if (ar_hs && !rlast_hs) begin
            rd_next = rd_outstanding + 1'b1;
        end else if (!ar_hs && rlast_hs && (rd_outstanding != '0)) begin
            rd_next = rd_outstanding - 1'b1;
        end
    end

    // W may lead AW, so w_pend is allowed to go negative.
    always_comb begin
        w_pend_next = w_pend;
        if (aw_hs && !wlast_hs) begin
            w_pend_next = w_pend + PEND_ONE;
        end else if (!aw_hs && wlast_hs) begin
            w_pend_next = w_pend - PEND_ONE;
        end
    end

    always_comb begin
        next_state  = state;
        timer_next  = timer;
        clean_enter = 1'b0;
        force_enter = 1'b0;
        case (state)
            ACTIVE: begin
                if (decouple_req) begin
                    next_state = DRAIN;
                    timer_next = '0;
                end
            end
            DRAIN: begin
                timer_next = timer + 1'b1;
                if (!decouple_req) begin
                    next_state = ACTIVE;
                end else if (idle) begin
                    next_state  = DECOUPLED;
                    clean_enter = 1'b1;
                end else if (timer == TMO_LAST) begin
                    next_state  = DECOUPLED;
                    force_enter = 1'b1;
                end
            end
            DECOUPLED: begin
                if (!decouple_req) begin
                    next_state = ACTIVE;
                end
            end
            default: begin
                next_state = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ACTIVE;
            timer         <= '0;
            decoupled     <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            state     <= next_state;
            timer     <= timer_next;
            decoupled <= (next_state == DECOUPLED);
            if (clean_enter) begin
                drain_timeout <= 1'b0;
            end else if (force_enter) begin
                drain_timeout <= 1'b1;
            end
        end
    end

    // A forced decouple abandons whatever was in flight, so tracking restarts.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_outstanding <= '0;
            rd_outstanding <= '0;
            w_pend         <= '0;
        end else if (force_enter) begin
            wr_outstanding <= '0;
            rd_outstanding <= '0;
            w_pend         <= '0;
        end else begin
            wr_outstanding <= wr_next;
            rd_outstanding <= rd_next;
            w_pend         <= w_pend_next;
        end
    end

endmodule

// File: tb/tb_axi_shell_decouple_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_shell_decouple_ctrl
// Directed bench for the AXI shell decouple controller: credit cap, clean and
// write drains, drain timeout, abort/recouple and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_axi_shell_decouple_ctrl;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       decouple_req;
    logic       decoupled;
    logic       drain_timeout;
    logic [5:0] wr_o;
    logic [5:0] rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    axi_shell_decouple_ctrl_if s_if ();
    axi_shell_decouple_ctrl_if m_if ();

    always #5 aclk = ~aclk;

    axi_shell_decouple_ctrl #(
        .MAX_OUTSTANDING (32),
        .CNT_BITS        (6),
        .DRAIN_TIMEOUT   (4096),
        .TMR_BITS        (16)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .decouple_req   (decouple_req),
        .decoupled      (decoupled),
        .drain_timeout  (drain_timeout),
        .wr_outstanding (wr_o),
        .rd_outstanding (rd_o),
        .s_axi          (s_if),
        .m_axi          (m_if)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        decouple_req  = 1'b0;
        s_if.awvalid  = 1'b0;
        s_if.arvalid  = 1'b0;
        s_if.wvalid   = 1'b0;
        s_if.wlast    = 1'b0;
        s_if.bready   = 1'b0;
        s_if.rready   = 1'b0;
        m_if.awready  = 1'b0;
        m_if.arready  = 1'b0;
        m_if.wready   = 1'b0;
        m_if.bvalid   = 1'b0;
        m_if.rvalid   = 1'b0;
        m_if.rlast    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        clear_inputs();
        aresetn = 1'b0;
        s_if.awvalid = 1'b1;
        #3;
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL reset_decoupled: got %b expected 0", decoupled); end
        n_tests++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_drain_timeout: got %b expected 0", drain_timeout); end
        n_tests++; if (wr_o !== 6'd0) begin n_fail++; $display("FAIL reset_wr: got %0d expected 0", wr_o); end
        n_tests++; if (rd_o !== 6'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", rd_o); end
        n_tests++; if (m_if.awvalid !== 1'b1) begin n_fail++; $display("FAIL reset_aw_pass: got %b expected 1", m_if.awvalid); end
        s_if.awvalid = 1'b0;
        do_reset();
    endtask

    task automatic test_credit_cap();
        do_reset();
        m_if.awready = 1'b1;
        s_if.awvalid = 1'b1;
        cyc(32);
        n_tests++; if (wr_o !== 6'd32) begin n_fail++; $display("FAIL cap_count: got %0d expected 32", wr_o); end
        n_tests++; if (s_if.awready !== 1'b0) begin n_fail++; $display("FAIL cap_awready: got %b expected 0", s_if.awready); end
        n_tests++; if (m_if.awvalid !== 1'b0) begin n_fail++; $display("FAIL cap_awvalid: got %b expected 0", m_if.awvalid); end
        cyc(1);
        n_tests++; if (wr_o !== 6'd32) begin n_fail++; $display("FAIL cap_hold: got %0d expected 32", wr_o); end
        m_if.bvalid = 1'b1;
        s_if.bready = 1'b1;
        #1;
        n_tests++; if (s_if.bvalid !== 1'b1) begin n_fail++; $display("FAIL cap_bvalid: got %b expected 1", s_if.bvalid); end
        cyc(1);
        m_if.bvalid = 1'b0;
        n_tests++; if (wr_o !== 6'd31) begin n_fail++; $display("FAIL cap_after_b: got %0d expected 31", wr_o); end
        n_tests++; if (s_if.awready !== 1'b1) begin n_fail++; $display("FAIL cap_reopen: got %b expected 1", s_if.awready); end
        cyc(1);
        s_if.awvalid = 1'b0;
        n_tests++; if (wr_o !== 6'd32) begin n_fail++; $display("FAIL cap_refill: got %0d expected 32", wr_o); end
        n_tests++; if (s_if.awready !== 1'b0) begin n_fail++; $display("FAIL cap_reclose: got %b expected 0", s_if.awready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_if.awready = 1'b1;
        s_if.awvalid = 1'b1;
        cyc(3);
        m_if.bvalid = 1'b1;
        s_if.bready = 1'b1;
        cyc(2);
        n_tests++; if (wr_o !== 6'd3) begin n_fail++; $display("FAIL b2b_wr_same: got %0d expected 3", wr_o); end
        s_if.awvalid = 1'b0;
        cyc(1);
        m_if.bvalid = 1'b0;
        n_tests++; if (wr_o !== 6'd2) begin n_fail++; $display("FAIL b2b_wr_dec: got %0d expected 2", wr_o); end
        m_if.arready = 1'b1;
        s_if.arvalid = 1'b1;
        cyc(2);
        m_if.rvalid = 1'b1;
        s_if.rready = 1'b1;
        m_if.rlast  = 1'b1;
        cyc(2);
        n_tests++; if (rd_o !== 6'd2) begin n_fail++; $display("FAIL b2b_rd_same: got %0d expected 2", rd_o); end
        s_if.arvalid = 1'b0;
        cyc(1);
        m_if.rlast = 1'b0;
        cyc(1);
        m_if.rvalid = 1'b0;
        n_tests++; if (rd_o !== 6'd1) begin n_fail++; $display("FAIL b2b_rd_nonlast: got %0d expected 1", rd_o); end
    endtask

    task automatic test_clean_drain();
        do_reset();
        m_if.arready = 1'b1;
        s_if.arvalid = 1'b1;
        cyc(2);
        s_if.arvalid = 1'b0;
        decouple_req = 1'b1;
        cyc(1);
        s_if.arvalid = 1'b1;
        m_if.rvalid  = 1'b1;
        s_if.rready  = 1'b1;
        #1;
        n_tests++; if (m_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL drain_ar_gated: got %b expected 0", m_if.arvalid); end
        n_tests++; if (s_if.arready !== 1'b0) begin n_fail++; $display("FAIL drain_arready: got %b expected 0", s_if.arready); end
        n_tests++; if (s_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL drain_r_pass: got %b expected 1", s_if.rvalid); end
        for (int i = 0; i < 8; i++) begin
            m_if.rlast = (i == 3) || (i == 7);
            cyc(1);
        end
        m_if.rvalid  = 1'b0;
        m_if.rlast   = 1'b0;
        s_if.arvalid = 1'b0;
        n_tests++; if (rd_o !== 6'd0) begin n_fail++; $display("FAIL drain_rd_zero: got %0d expected 0", rd_o); end
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL drain_not_yet: got %b expected 0", decoupled); end
        cyc(1);
        n_tests++; if (decoupled !== 1'b1) begin n_fail++; $display("FAIL drain_decoupled: got %b expected 1", decoupled); end
        n_tests++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL drain_no_timeout: got %b expected 0", drain_timeout); end
        m_if.rvalid = 1'b1;
        #1;
        n_tests++; if (s_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL drain_r_gated: got %b expected 0", s_if.rvalid); end
        m_if.rvalid = 1'b0;
    endtask

    task automatic test_write_drain();
        do_reset();
        m_if.awready = 1'b1;
        s_if.awvalid = 1'b1;
        cyc(1);
        s_if.awvalid = 1'b0;
        decouple_req = 1'b1;
        cyc(1);
        n_tests++; if (s_if.awready !== 1'b0) begin n_fail++; $display("FAIL wdrain_aw_gated: got %b expected 0", s_if.awready); end
        m_if.wready = 1'b1;
        s_if.wvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_if.wlast = (i == 7);
            cyc(1);
        end
        s_if.wvalid = 1'b0;
        s_if.wlast  = 1'b0;
        n_tests++; if (dut.w_pend !== 7'sd0) begin n_fail++; $display("FAIL wdrain_wpend: got %0d expected 0", dut.w_pend); end
        n_tests++; if (wr_o !== 6'd1) begin n_fail++; $display("FAIL wdrain_wr_one: got %0d expected 1", wr_o); end
        cyc(2);
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL wdrain_wait_b: got %b expected 0", decoupled); end
        m_if.bvalid = 1'b1;
        s_if.bready = 1'b1;
        cyc(1);
        m_if.bvalid = 1'b0;
        n_tests++; if (wr_o !== 6'd0) begin n_fail++; $display("FAIL wdrain_wr_zero: got %0d expected 0", wr_o); end
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL wdrain_b_edge: got %b expected 0", decoupled); end
        cyc(1);
        n_tests++; if (decoupled !== 1'b1) begin n_fail++; $display("FAIL wdrain_decoupled: got %b expected 1", decoupled); end
        n_tests++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL wdrain_no_timeout: got %b expected 0", drain_timeout); end
    endtask

    task automatic test_timeout();
        do_reset();
        m_if.arready = 1'b1;
        s_if.arvalid = 1'b1;
        cyc(1);
        s_if.arvalid = 1'b0;
        decouple_req = 1'b1;
        cyc(1);
        cyc(4095);
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", decoupled); end
        n_tests++; if (rd_o !== 6'd1) begin n_fail++; $display("FAIL tmo_rd_held: got %0d expected 1", rd_o); end
        cyc(1);
        n_tests++; if (decoupled !== 1'b1) begin n_fail++; $display("FAIL tmo_decoupled: got %b expected 1", decoupled); end
        n_tests++; if (drain_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", drain_timeout); end
        n_tests++; if (rd_o !== 6'd0) begin n_fail++; $display("FAIL tmo_rd_clear: got %0d expected 0", rd_o); end
        decouple_req = 1'b0;
        cyc(1);
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL tmo_release: got %b expected 0", decoupled); end
        n_tests++; if (drain_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", drain_timeout); end
        n_tests++; if (s_if.arready !== 1'b1) begin n_fail++; $display("FAIL tmo_ar_open: got %b expected 1", s_if.arready); end
        decouple_req = 1'b1;
        cyc(2);
        n_tests++; if (decoupled !== 1'b1) begin n_fail++; $display("FAIL tmo_clean_again: got %b expected 1", decoupled); end
        n_tests++; if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_flag_cleared: got %b expected 0", drain_timeout); end
    endtask

    task automatic test_abort_recouple();
        do_reset();
        m_if.awready = 1'b1;
        m_if.arready = 1'b1;
        s_if.awvalid = 1'b1;
        cyc(1);
        s_if.awvalid = 1'b0;
        s_if.arvalid = 1'b1;
        cyc(1);
        s_if.arvalid = 1'b0;
        decouple_req = 1'b1;
        cyc(1);
        n_tests++; if (s_if.awready !== 1'b0) begin n_fail++; $display("FAIL abort_aw_gated: got %b expected 0", s_if.awready); end
        n_tests++; if (s_if.arready !== 1'b0) begin n_fail++; $display("FAIL abort_ar_gated: got %b expected 0", s_if.arready); end
        cyc(2);
        decouple_req = 1'b0;
        cyc(1);
        n_tests++; if (s_if.awready !== 1'b1) begin n_fail++; $display("FAIL abort_aw_open: got %b expected 1", s_if.awready); end
        n_tests++; if (wr_o !== 6'd1) begin n_fail++; $display("FAIL abort_wr_kept: got %0d expected 1", wr_o); end
        n_tests++; if (rd_o !== 6'd1) begin n_fail++; $display("FAIL abort_rd_kept: got %0d expected 1", rd_o); end
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL abort_decoupled: got %b expected 0", decoupled); end

        do_reset();
        m_if.awready = 1'b1;
        m_if.arready = 1'b1;
        m_if.wready  = 1'b1;
        m_if.bvalid  = 1'b1;
        decouple_req = 1'b1;
        cyc(2);
        n_tests++; if (decoupled !== 1'b1) begin n_fail++; $display("FAIL recouple_entry: got %b expected 1", decoupled); end
        n_tests++; if (s_if.wready !== 1'b0) begin n_fail++; $display("FAIL recouple_w_gated: got %b expected 0", s_if.wready); end
        n_tests++; if (s_if.bvalid !== 1'b0) begin n_fail++; $display("FAIL recouple_b_gated: got %b expected 0", s_if.bvalid); end
        decouple_req = 1'b0;
        cyc(1);
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL recouple_exit: got %b expected 0", decoupled); end
        n_tests++; if (s_if.wready !== 1'b1) begin n_fail++; $display("FAIL recouple_w_open: got %b expected 1", s_if.wready); end
        n_tests++; if (s_if.bvalid !== 1'b1) begin n_fail++; $display("FAIL recouple_b_open: got %b expected 1", s_if.bvalid); end
        n_tests++; if (s_if.awready !== 1'b1) begin n_fail++; $display("FAIL recouple_aw_open: got %b expected 1", s_if.awready); end
        n_tests++; if (s_if.arready !== 1'b1) begin n_fail++; $display("FAIL recouple_ar_open: got %b expected 1", s_if.arready); end
        m_if.bvalid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        m_if.awready = 1'b1;
        s_if.awvalid = 1'b1;
        cyc(5);
        s_if.awvalid = 1'b0;
        decouple_req = 1'b1;
        cyc(1);
        n_tests++; if (wr_o !== 6'd5) begin n_fail++; $display("FAIL arst_pre_wr: got %0d expected 5", wr_o); end
        #2;
        aresetn = 1'b0;
        #1;
        n_tests++; if (wr_o !== 6'd0) begin n_fail++; $display("FAIL arst_wr: got %0d expected 0", wr_o); end
        n_tests++; if (dut.w_pend !== 7'sd0) begin n_fail++; $display("FAIL arst_wpend: got %0d expected 0", dut.w_pend); end
        n_tests++; if (decoupled !== 1'b0) begin n_fail++; $display("FAIL arst_decoupled: got %b expected 0", decoupled); end
        n_tests++; if (s_if.awready !== 1'b1) begin n_fail++; $display("FAIL arst_active: got %b expected 1", s_if.awready); end
        decouple_req = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        cyc(1);
        n_tests++; if (s_if.awready !== 1'b1) begin n_fail++; $display("FAIL arst_after_release: got %b expected 1", s_if.awready); end
        n_tests++; if (wr_o !== 6'd0) begin n_fail++; $display("FAIL arst_wr_after: got %0d expected 0", wr_o); end
    endtask

    initial begin
        test_reset();
        test_credit_cap();
        test_back_to_back();
        test_clean_drain();
        test_write_drain();
        test_timeout();
        test_abort_recouple();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_shell_decouple_ctrl.md
Name: axi_shell_decouple_ctrl

Overview:
- Handshake-level controller placed beside the shell-to-user AXI4 register slice.
- Gates the valid/ready pairs of all five AXI4 channels and tracks outstanding transactions.
- Limits in-flight reads and writes to a credit cap.
- On request, stops new address acceptance, drains in-flight bursts, then fully decouples the user region for partial reconfiguration.
- Payload signals bypass this block; only handshakes pass through it.

Parameters:
MAX_OUTSTANDING  32  cap on accepted-but-unanswered transactions per direction
CNT_BITS  6  width of the outstanding counters (must represent MAX_OUTSTANDING)
DRAIN_TIMEOUT  4096  maximum DRAIN cycles before a forced decouple
TMR_BITS  16  width of the drain timer

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
decouple_req  in  1  level request to decouple
decoupled  out  1  user side isolated
drain_timeout  out  1  sticky: last drain was forced by timeout
wr_outstanding  out  CNT_BITS  AW accepted minus B accepted
rd_outstanding  out  CNT_BITS  AR accepted minus R-last accepted
s_axi_awvalid/s_axi_awready  in/out  1  slave-side AW handshake
m_axi_awvalid/m_axi_awready  out/in  1  master-side AW handshake
s_axi_arvalid/s_axi_arready  in/out  1  slave-side AR handshake
m_axi_arvalid/m_axi_arready  out/in  1  master-side AR handshake
s_axi_wvalid/s_axi_wready/s_axi_wlast  in/out/in  1  slave-side W handshake
m_axi_wvalid/m_axi_wready  out/in  1  master-side W handshake
m_axi_bvalid/m_axi_bready  in/out  1  master-side B handshake
s_axi_bvalid/s_axi_bready  out/in  1  slave-side B handshake
m_axi_rvalid/m_axi_rready/m_axi_rlast  in/out/in  1  master-side R handshake
s_axi_rvalid/s_axi_rready  out/in  1  slave-side R handshake

Behaviour:
- Clock and reset: single clock aclk; reset aresetn is asynchronous and active-low.
- Reset values: state=ACTIVE, all counters 0, timer 0, decoupled=0, drain_timeout=0. Reset mid-burst discards all tracking.
- Gating:
  - Enables are derived only from registered state and counters, giving zero-latency combinational pass-through.
  - Forward channel: m_valid = s_valid & en; s_ready = m_ready & en.
  - Response channel: s_valid = m_valid & en; m_ready = s_ready & en.
- Enables:
  - aw_en = (state==ACTIVE) & (wr_outstanding < MAX_OUTSTANDING).
  - ar_en = (state==ACTIVE) & (rd_outstanding < MAX_OUTSTANDING).
  - w_en, b_en, r_en = (state != DECOUPLED).
- Counters (all updates are simultaneous-safe):
  - wr_outstanding: +1 on AW handshake, -1 on B handshake; both in the same cycle leave it unchanged.
  - rd_outstanding: +1 on AR handshake, -1 on R handshake with rlast.
  - w_pend (signed, CNT_BITS+1 bits): +1 on AW handshake, -1 on W handshake with wlast. It may go negative when W leads AW.
  - Counters never wrap. The cap prevents overflow; a decrement at 0 is a protocol error and saturates at 0 (verification asserts this never happens).
- FSM:
  - ACTIVE: on decouple_req=1, go to DRAIN and clear the timer.
  - DRAIN: timer +1 per cycle.
    - If decouple_req=0, return to ACTIVE.
    - Else if wr_outstanding==0 & rd_outstanding==0 & w_pend==0, go to DECOUPLED and set drain_timeout=0.
    - Else if timer==DRAIN_TIMEOUT-1, go to DECOUPLED and set drain_timeout=1.
    - The idle condition takes priority over timeout in the same cycle.
  - DECOUPLED: decoupled=1 (registered, asserted the cycle after entry). On decouple_req=0, go to ACTIVE; decoupled falls on the next cycle.
  - On a forced decouple, all counters are cleared on DECOUPLED entry. drain_timeout holds until the next DRAIN→DECOUPLED transition or reset.
- A handshake completing in the same cycle as a state change is counted; gating applies from the next cycle.

Test Plan:
- Credit cap: 32 AWs accepted with B withheld → s_axi_awready=0 while wr_outstanding=32. One B accepted → next AW accepted, count stays 32.
- Clean drain: 2 reads of 4 beats in flight, decouple_req=1 → ar gated immediately; R beats still pass. decoupled=1 one cycle after the last rlast, drain_timeout=0.
- Write drain with W after AW: AW accepted, decouple_req=1, 8 W beats then B → DECOUPLED only after the B handshake; w_pend and wr_outstanding both 0.
- Timeout: AR accepted, R never returned, decouple_req=1 → decoupled=1 after 4096 DRAIN cycles, drain_timeout=1, rd_outstanding=0.
- Abort and recouple: decouple_req pulsed 3 cycles during DRAIN → back to ACTIVE with counters preserved. Later, decouple_req dropped while DECOUPLED → all enables restored, decoupled=0.
- Async reset asserted mid-burst (wr_outstanding=5, DRAIN) → all outputs and counters 0 immediately, state ACTIVE after release.
